// File: rtl/xgmii_pattern_pkg.sv
// Shared definitions for the XGMII pattern generator and loopback checker:
// the pattern table, index helpers and the checker state encoding.
package xgmii_pattern_pkg;

  localparam int         NUM_PATTERNS = 6;
  localparam logic [2:0] IDLE_IDX     = 3'd5;
  localparam logic [2:0] LAST_IDX     = 3'(NUM_PATTERNS - 1);

  typedef enum logic {
    CHK_HUNT = 1'b0,
    CHK_LOCK = 1'b1
  } chk_state_e;

  function automatic logic [7:0] pat_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'hFF;
      3'd1:    return 8'h00;
      3'd2:    return 8'h55;
      3'd3:    return 8'hAA;
      3'd4:    return 8'hFE;
      default: return 8'h07;
    endcase
  endfunction

  // Control lanes are either all set or all clear for a given pattern.
  function automatic logic pat_ctrl(input logic [2:0] idx);
    return (idx == 3'd4) || (idx == 3'd5);
  endfunction

  function automatic logic [2:0] next_idx(input logic [2:0] idx);
    return (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/xgmii_pattern_chk.sv
// Loopback checker: locks onto the cyclic pattern sequence at any latency and
// flags mismatches and dwell violations. XGMII_PATTERN_LB_TIMEOUT_EN adds chk_timeout.
module xgmii_pattern_chk
  import xgmii_pattern_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int DWELL_CYCLES    = 100,
  parameter int LOSS_THRESH     = 4,
  parameter int ERR_COUNT_WIDTH = 16,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       chk_enable,
  input  logic                       chk_clear,
  input  logic [DATA_WIDTH-1:0]      xgmii_rxd,
  input  logic [CTRL_WIDTH-1:0]      xgmii_rxc,
  output logic [2:0]                 chk_pattern_idx,
  output logic                       chk_lock,
  output logic                       chk_error,
`ifdef XGMII_PATTERN_LB_TIMEOUT_EN
  output logic                       chk_timeout,
  output logic [ERR_COUNT_WIDTH-1:0] chk_err_count
`else
  output logic [ERR_COUNT_WIDTH-1:0] chk_err_count
`endif
);

  localparam int RW = $clog2(DWELL_CYCLES + 1);
  localparam int LW = $clog2(LOSS_THRESH + 1);

  chk_state_e                 state_q, state_d;
  logic [2:0]                 exp_q, exp_d;
  logic [RW-1:0]              run_q, run_d;
  logic                       aligned_q, aligned_d;
  logic [LW-1:0]              consec_q, consec_d;
  logic                       err_q, err_d;
  logic [ERR_COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                       match_any;
  logic [2:0]                 match_idx;

  always_comb begin
    match_any = 1'b0;
    match_idx = 3'd0;
    for (int p = 0; p < NUM_PATTERNS; p++) begin
      if (xgmii_rxd == {CTRL_WIDTH{pat_byte(3'(p))}} &&
          xgmii_rxc == {CTRL_WIDTH{pat_ctrl(3'(p))}}) begin
        match_any = 1'b1;
        match_idx = 3'(p);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    run_d     = run_q;
    aligned_d = aligned_q;
    consec_d  = consec_q;
    err_d     = 1'b0;
    if (!chk_enable) begin
      state_d = CHK_HUNT;
    end else begin
      case (state_q)
        CHK_HUNT: begin
          if (match_any) begin
            state_d   = CHK_LOCK;
            exp_d     = match_idx;
            run_d     = RW'(1);
            aligned_d = 1'b0;
            consec_d  = '0;
          end
        end
        CHK_LOCK: begin
          if (match_any && match_idx == exp_q) begin
            if (run_q == RW'(DWELL_CYCLES)) err_d = 1'b1;
            else                            run_d = run_q + 1'b1;
          end else if (match_any && match_idx == next_idx(exp_q)) begin
            // The first transition after hunting has no known run start.
            err_d     = aligned_q && (run_q != RW'(DWELL_CYCLES));
            exp_d     = next_idx(exp_q);
            run_d     = RW'(1);
            aligned_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          if (err_d) begin
            consec_d = consec_q + 1'b1;
            if (consec_d >= LW'(LOSS_THRESH)) state_d = CHK_HUNT;
          end else begin
            consec_d = '0;
          end
        end
        default: state_d = CHK_HUNT;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (chk_clear) cnt_d = '0;
    if (err_d && cnt_d != '1) cnt_d = cnt_d + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CHK_HUNT;
      exp_q     <= 3'd0;
      run_q     <= '0;
      aligned_q <= 1'b0;
      consec_q  <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      run_q     <= run_d;
      aligned_q <= aligned_d;
      consec_q  <= consec_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign chk_pattern_idx = exp_q;
  assign chk_lock        = (state_q == CHK_LOCK);
  assign chk_error       = err_q;
  assign chk_err_count   = cnt_q;

`ifdef XGMII_PATTERN_LB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tflag_q, tflag_d;

  always_comb begin
    tcnt_d  = tcnt_q;
    tflag_d = tflag_q;
    if (state_d == CHK_LOCK) begin
      tcnt_d  = '0;
      tflag_d = 1'b0;
    end else if (state_q == CHK_HUNT && chk_enable) begin
      if (tcnt_q != TW'(TIMEOUT_CYCLES)) tcnt_d = tcnt_q + 1'b1;
      if (tcnt_d == TW'(TIMEOUT_CYCLES)) tflag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q  <= '0;
      tflag_q <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      tflag_q <= tflag_d;
    end
  end

  assign chk_timeout = tflag_q;
`endif

endmodule

// File: rtl/xgmii_pattern_lb.sv
// XGMII test-pattern generator with loopback checker. Defining
// XGMII_PATTERN_LB_TIMEOUT_EN adds the chk_timeout hunt-timeout output.
module xgmii_pattern_lb
  import xgmii_pattern_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int DWELL_CYCLES    = 100,
  parameter int LOSS_THRESH     = 4,
  parameter int ERR_COUNT_WIDTH = 16,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       gen_enable,
  input  logic                       chk_enable,
  input  logic                       chk_clear,
  output logic [DATA_WIDTH-1:0]      xgmii_txd,
  output logic [CTRL_WIDTH-1:0]      xgmii_txc,
  input  logic [DATA_WIDTH-1:0]      xgmii_rxd,
  input  logic [CTRL_WIDTH-1:0]      xgmii_rxc,
  output logic [2:0]                 gen_pattern_idx,
  output logic [2:0]                 chk_pattern_idx,
  output logic                       chk_lock,
  output logic                       chk_error,
`ifdef XGMII_PATTERN_LB_TIMEOUT_EN
  output logic                       chk_timeout,
  output logic [ERR_COUNT_WIDTH-1:0] chk_err_count
`else
  output logic [ERR_COUNT_WIDTH-1:0] chk_err_count
`endif
);

  localparam int DW = $clog2(DWELL_CYCLES + 1);

  logic [DW-1:0]         dwell_q, dwell_d;
  logic [2:0]            gidx_q, gidx_d;
  logic [DATA_WIDTH-1:0] txd_q, txd_d;
  logic [CTRL_WIDTH-1:0] txc_q, txc_d;

  // A zero dwell count marks the idle state, so the first enabled cycle starts pattern 0.
  always_comb begin
    dwell_d = '0;
    gidx_d  = 3'd0;
    txd_d   = {CTRL_WIDTH{pat_byte(IDLE_IDX)}};
    txc_d   = '1;
    if (gen_enable) begin
      if (dwell_q == '0) begin
        dwell_d = DW'(1);
      end else if (dwell_q == DW'(DWELL_CYCLES)) begin
        gidx_d  = next_idx(gidx_q);
        dwell_d = DW'(1);
      end else begin
        gidx_d  = gidx_q;
        dwell_d = dwell_q + 1'b1;
      end
      txd_d = {CTRL_WIDTH{pat_byte(gidx_d)}};
      txc_d = {CTRL_WIDTH{pat_ctrl(gidx_d)}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q <= '0;
      gidx_q  <= 3'd0;
      txd_q   <= {CTRL_WIDTH{pat_byte(IDLE_IDX)}};
      txc_q   <= '1;
    end else begin
      dwell_q <= dwell_d;
      gidx_q  <= gidx_d;
      txd_q   <= txd_d;
      txc_q   <= txc_d;
    end
  end

  assign xgmii_txd       = txd_q;
  assign xgmii_txc       = txc_q;
  assign gen_pattern_idx = gidx_q;

  xgmii_pattern_chk #(
    .DATA_WIDTH      (DATA_WIDTH),
    .CTRL_WIDTH      (CTRL_WIDTH),
    .DWELL_CYCLES    (DWELL_CYCLES),
    .LOSS_THRESH     (LOSS_THRESH),
    .ERR_COUNT_WIDTH (ERR_COUNT_WIDTH),
    .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
  ) u_chk (
    .clk             (clk),
    .rst             (rst),
    .chk_enable      (chk_enable),
    .chk_clear       (chk_clear),
    .xgmii_rxd       (xgmii_rxd),
    .xgmii_rxc       (xgmii_rxc),
    .chk_pattern_idx (chk_pattern_idx),
    .chk_lock        (chk_lock),
    .chk_error       (chk_error),
`ifdef XGMII_PATTERN_LB_TIMEOUT_EN
    .chk_timeout     (chk_timeout),
`endif
    .chk_err_count   (chk_err_count)
  );

endmodule

// File: tb/tb_xgmii_pattern_lb.sv
// Bench for xgmii_pattern_lb: 3-cycle loopback, directed scenarios and random
// corruption, every cycle compared against a behavioural model of the pattern rules.
module tb_xgmii_pattern_lb;

  localparam int DW    = 64;
  localparam int CW    = 8;
  localparam int DWELL = 8;
  localparam int LOSS  = 4;
  localparam int ECW   = 4;
  localparam int TMO   = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          gen_enable, chk_enable, chk_clear;
  logic [DW-1:0] xgmii_txd, xgmii_rxd;
  logic [CW-1:0] xgmii_txc, xgmii_rxc;
  logic [2:0]    gen_pattern_idx, chk_pattern_idx;
  logic          chk_lock, chk_error;
  logic [ECW-1:0] chk_err_count;
`ifdef XGMII_PATTERN_LB_TIMEOUT_EN
  logic          chk_timeout;
`endif

  always #5 clk = ~clk;

  xgmii_pattern_lb #(
    .DATA_WIDTH (DW), .CTRL_WIDTH (CW), .DWELL_CYCLES (DWELL),
    .LOSS_THRESH (LOSS), .ERR_COUNT_WIDTH (ECW), .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk (clk), .rst (rst),
    .gen_enable (gen_enable), .chk_enable (chk_enable), .chk_clear (chk_clear),
    .xgmii_txd (xgmii_txd), .xgmii_txc (xgmii_txc),
    .xgmii_rxd (xgmii_rxd), .xgmii_rxc (xgmii_rxc),
    .gen_pattern_idx (gen_pattern_idx), .chk_pattern_idx (chk_pattern_idx),
    .chk_lock (chk_lock), .chk_error (chk_error),
`ifdef XGMII_PATTERN_LB_TIMEOUT_EN
    .chk_timeout (chk_timeout),
`endif
    .chk_err_count (chk_err_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [7:0] byte_tab [0:5] = '{8'hFF, 8'h00, 8'h55, 8'hAA, 8'hFE, 8'h07};
  bit         ctrl_tab [0:5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  function automatic logic [DW-1:0] word_of(input int p);
    logic [7:0] b;
    b = byte_tab[p];
    return {CW{b}};
  endfunction

  function automatic logic [CW-1:0] ctrl_of(input int p);
    return ctrl_tab[p] ? '1 : '0;
  endfunction

  function automatic int classify(input logic [DW-1:0] d, input logic [CW-1:0] c);
    for (int p = 0; p < 6; p++)
      if (d == word_of(p) && c == ctrl_of(p)) return p;
    return -1;
  endfunction

  // Reference state: generator as "cycles since enable", checker as plain integers.
  int g_t, m_lock, m_exp, m_run, m_al, m_consec, m_cnt, m_err, m_tc, m_to;
  logic [DW-1:0] txq[$];
  logic [CW-1:0] tcq[$];
  bit            ovr;
  logic [DW-1:0] ovr_d;
  logic [CW-1:0] ovr_c;

  task automatic model_reset();
    g_t = 0; m_lock = 0; m_exp = 0; m_run = 0; m_al = 0; m_consec = 0;
    m_cnt = 0; m_err = 0; m_tc = 0; m_to = 0;
    txq.delete(); tcq.delete();
  endtask

  task automatic model_update(input logic [DW-1:0] d, input logic [CW-1:0] c);
    int p, was_lock;
    p = classify(d, c);
    was_lock = m_lock;
    if (gen_enable) g_t++; else g_t = 0;
    m_err = 0;
    if (!chk_enable) m_lock = 0;
    else if (m_lock == 0) begin
      if (p >= 0) begin m_lock = 1; m_exp = p; m_run = 1; m_al = 0; m_consec = 0; end
    end else begin
      if (p == m_exp) begin
        if (m_run + 1 > DWELL) m_err = 1; else m_run++;
      end else if (p >= 0 && p == (m_exp + 1) % 6) begin
        if (m_al == 1 && m_run != DWELL) m_err = 1;
        m_exp = (m_exp + 1) % 6; m_run = 1; m_al = 1;
      end else m_err = 1;
      if (m_err == 1) begin
        m_consec++;
        if (m_consec >= LOSS) m_lock = 0;
      end else m_consec = 0;
    end
    if (chk_clear) m_cnt = 0;
    if (m_err == 1 && m_cnt < (1 << ECW) - 1) m_cnt++;
    if (m_lock == 1) begin m_tc = 0; m_to = 0; end
    else if (chk_enable && was_lock == 0) begin
      if (m_tc < TMO) m_tc++;
      if (m_tc >= TMO) m_to = 1;
    end
  endtask

  task automatic compare_all();
    int gp;
    gp = (g_t == 0) ? 5 : ((g_t - 1) / DWELL) % 6;
    check_eq("txd", 64'(xgmii_txd), 64'(word_of(gp)));
    check_eq("txc", 64'(xgmii_txc), 64'(ctrl_of(gp)));
    check_eq("gen_idx", 64'(gen_pattern_idx), 64'((g_t == 0) ? 0 : gp));
    check_eq("chk_lock", 64'(chk_lock), 64'(m_lock));
    check_eq("chk_idx", 64'(chk_pattern_idx), 64'(m_exp));
    check_eq("chk_error", 64'(chk_error), 64'(m_err));
    check_eq("err_count", 64'(chk_err_count), 64'(m_cnt));
`ifdef XGMII_PATTERN_LB_TIMEOUT_EN
    check_eq("timeout", 64'(chk_timeout), 64'(m_to));
`endif
  endtask

  // Called at a falling edge: loop back txd from three cycles ago, then one clock.
  task automatic step();
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    txq.push_back(xgmii_txd);
    tcq.push_back(xgmii_txc);
    if (txq.size() > 8) begin void'(txq.pop_front()); void'(tcq.pop_front()); end
    if (ovr) begin d = ovr_d; c = ovr_c; end
    else if (txq.size() >= 4) begin d = txq[txq.size() - 4]; c = tcq[tcq.size() - 4]; end
    else begin d = word_of(5); c = ctrl_of(5); end
    xgmii_rxd = d;
    xgmii_rxc = c;
    model_update(d, c);
    @(posedge clk); #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    check_eq({tag, "_txd"},  64'(xgmii_txd), 64'(word_of(5)));
    check_eq({tag, "_txc"},  64'(xgmii_txc), 64'hFF);
    check_eq({tag, "_gidx"}, 64'(gen_pattern_idx), 64'd0);
    check_eq({tag, "_cidx"}, 64'(chk_pattern_idx), 64'd0);
    check_eq({tag, "_lock"}, 64'(chk_lock), 64'd0);
    check_eq({tag, "_err"},  64'(chk_error), 64'd0);
    check_eq({tag, "_cnt"},  64'(chk_err_count), 64'd0);
  endtask

  initial begin
    int chk_off, gen_off;
    rst = 1'b1; gen_enable = 1'b0; chk_enable = 1'b0; chk_clear = 1'b0;
    ovr = 1'b0; ovr_d = '0; ovr_c = '0;
    xgmii_rxd = word_of(5); xgmii_rxc = ctrl_of(5);
    model_reset();
    @(negedge clk); @(negedge clk);
    reset_checks("reset");
    rst = 1'b0;

    // Clean loopback
    gen_enable = 1'b1; chk_enable = 1'b1;
    repeat (10) step();
    check_eq("lock_early", 64'(chk_lock), 64'd1);
    repeat (192) step();
    check_eq("clean_count", 64'(chk_err_count), 64'd0);

    // Single corrupt word mid-run
    repeat (3) step();
    ovr = 1'b1; ovr_d = 64'h1234; ovr_c = '0;
    step();
    check_eq("corrupt_pulse", 64'(chk_error), 64'd1);
    ovr = 1'b0;
    step();
    check_eq("corrupt_lock_held", 64'(chk_lock), 64'd1);
    repeat (20) step();

    // Four consecutive corrupt words drop lock, next valid word relocks
    chk_clear = 1'b1; step(); chk_clear = 1'b0;
    ovr = 1'b1;
    repeat (3) step();
    check_eq("burst_lock_3", 64'(chk_lock), 64'd1);
    step();
    check_eq("burst_lock_4", 64'(chk_lock), 64'd0);
    check_eq("burst_cnt", 64'(chk_err_count), 64'd4);
    ovr = 1'b0;
    step();
    check_eq("relock", 64'(chk_lock), 64'd1);
    repeat (20) step();

    // Pattern 2 held for 12 words from HUNT: overrun on words 9..12
    chk_enable = 1'b0; chk_clear = 1'b1; step();
    chk_enable = 1'b1; chk_clear = 1'b0;
    ovr = 1'b1; ovr_d = word_of(2); ovr_c = ctrl_of(2);
    for (int k = 1; k <= 12; k++) begin
      step();
      check_eq("overrun_cnt", 64'(chk_err_count), 64'((k > 8) ? k - 8 : 0));
    end
    check_eq("overrun_unlock", 64'(chk_lock), 64'd0);
    ovr = 1'b0;
    repeat (30) step();

    // Random corruption, clears, enable drops and pattern holds
    chk_off = 0; gen_off = 0;
    repeat (700) begin
      chk_clear = ($urandom_range(0, 39) == 0);
      ovr = 1'b0;
      case ($urandom_range(0, 39))
        0: begin ovr = 1'b1; ovr_d = {$urandom, $urandom}; ovr_c = 8'($urandom); end
        1: begin ovr = 1'b1; ovr_d = word_of($urandom_range(0, 5)); ovr_c = '0; end
        2: begin
          ovr = 1'b1;
          begin int p; p = $urandom_range(0, 5); ovr_d = word_of(p); ovr_c = ctrl_of(p); end
        end
        default: ;
      endcase
      if (chk_off > 0) begin chk_enable = 1'b0; chk_off--; end
      else begin chk_enable = 1'b1; if ($urandom_range(0, 99) == 0) chk_off = $urandom_range(1, 5); end
      if (gen_off > 0) begin gen_enable = 1'b0; gen_off--; end
      else begin gen_enable = 1'b1; if ($urandom_range(0, 149) == 0) gen_off = $urandom_range(1, 12); end
      step();
    end
    ovr = 1'b0; chk_clear = 1'b0; chk_enable = 1'b1; gen_enable = 1'b1;
    repeat (13) step();

    // Asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1 reset_checks("async");
    model_reset();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset_checks("async_hold");
    rst = 1'b0;
    repeat (40) step();

    // Garbage held until the checker gives up, then valid loopback restored
    ovr = 1'b1; ovr_d = 64'h1234; ovr_c = '0;
    repeat (4 + TMO - 1) step();
`ifdef XGMII_PATTERN_LB_TIMEOUT_EN
    check_eq("timeout_early", 64'(chk_timeout), 64'd0);
`endif
    step();
`ifdef XGMII_PATTERN_LB_TIMEOUT_EN
    check_eq("timeout_set", 64'(chk_timeout), 64'd1);
`endif
    ovr = 1'b0;
    repeat (10) step();
    check_eq("final_lock", 64'(chk_lock), 64'd1);
`ifdef XGMII_PATTERN_LB_TIMEOUT_EN
    check_eq("timeout_clear", 64'(chk_timeout), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xgmii_pattern_lb.md
Name: xgmii_pattern_lb

Overview:
- Synthesizable XGMII test-pattern generator plus loopback checker, replacing the behavioural pattern stimulus in the 10G PHY benches.
- Generator drives the eth_phy_10g XGMII TX interface with a fixed cyclic sequence of byte-replicated patterns. Each pattern is held for DWELL_CYCLES.
- Checker watches the XGMII RX interface, locks to the sequence regardless of loopback latency, and counts mismatches and dwell violations.
- Usable in hardware bring-up and in simulation.

Parameters:
- DATA_WIDTH, 64, XGMII data width; must be 32 or 64.
- CTRL_WIDTH, DATA_WIDTH/8, XGMII control width.
- DWELL_CYCLES, 100, cycles each pattern is held; must be >= 2.
- LOSS_THRESH, 4, consecutive bad words that drop lock.
- ERR_COUNT_WIDTH, 16, width of the saturating error counter.
- TIMEOUT_CYCLES, 4096, hunt timeout (optional feature only).

Ports:
- clk  in  1  single clock, tx_clk domain.
- rst  in  1  asynchronous, active-high reset.
- gen_enable  in  1  generator run.
- chk_enable  in  1  checker run.
- chk_clear  in  1  synchronous clear of chk_err_count.
- xgmii_txd  out  DATA_WIDTH  generated data.
- xgmii_txc  out  CTRL_WIDTH  generated control.
- xgmii_rxd  in  DATA_WIDTH  received data.
- xgmii_rxc  in  CTRL_WIDTH  received control.
- gen_pattern_idx  out  3  index of the pattern currently transmitted.
- chk_pattern_idx  out  3  expected pattern index.
- chk_lock  out  1  checker locked.
- chk_error  out  1  one-cycle pulse per detected error.
- chk_err_count  out  ERR_COUNT_WIDTH  saturating error total.

Behaviour:
- Pattern table, with the byte replicated across the word. Index: byte / txc.
  - 0: FF / 0
  - 1: 00 / 0
  - 2: 55 / 0
  - 3: AA / 0
  - 4: FE / all ones
  - 5: 07 / all ones
- A received word matches pattern p only if both rxd and rxc are equal.
- Reset: xgmii_txd = 07 replicated; xgmii_txc = all ones; gen_pattern_idx = 0; chk_pattern_idx = 0; chk_lock = 0; chk_error = 0; chk_err_count = 0; checker state HUNT.
- All outputs are registered.
- Generator:
  - gen_enable low: output idle (pattern 5 values); index = 0; dwell counter = 0.
  - Cycle after gen_enable rises: pattern 0 is output with dwell count 1.
  - Index advances after exactly DWELL_CYCLES cycles and wraps 5 -> 0.
  - gen_enable dropping mid-dwell returns to idle on the next cycle.
- Checker FSM, states HUNT and LOCK; held in HUNT while chk_enable is low.
  - HUNT: a word matching any pattern p moves to LOCK next cycle with expected = p, run = 1, aligned = 0, consec_err = 0.
  - LOCK, word equals expected: run += 1. If run would exceed DWELL_CYCLES, that is a dwell-overrun error; run saturates.
  - LOCK, word equals expected+1 (mod 6): transition. If aligned = 1 and run != DWELL_CYCLES, that is a short-dwell error. In all cases expected advances, run = 1, aligned = 1.
  - LOCK, any other word: mismatch error; expected and run hold.
  - On any error: chk_error pulses, chk_err_count increments (saturates at all ones), consec_err += 1. Reaching LOSS_THRESH -> HUNT with chk_lock = 0.
  - Any good word clears consec_err.
  - chk_lock = 1 exactly while in LOCK.
- chk_clear zeroes the counter. If chk_clear coincides with an error, the counter ends at 1.
- chk_enable falling returns to HUNT; chk_err_count is kept.

Optional Feature:
- Macro XGMII_PATTERN_LB_TIMEOUT_EN.
- Defined: adds output chk_timeout (1 bit). A counter runs while in HUNT with chk_enable high. After TIMEOUT_CYCLES without lock, chk_timeout is set and stays set until lock or reset. Entering LOCK clears the counter and the flag.
- Undefined: no port, no counter.

Decomposition:
- Package xgmii_pattern_pkg: pattern byte table, pattern control flags, NUM_PATTERNS = 6, IDLE_IDX = 5, checker state encoding.
- One sub-module, xgmii_pattern_chk, holds the checker FSM and counters. The top holds the generator and instantiates the checker.

Test Plan:
- Loopback, 3-cycle delay, DWELL_CYCLES = 8, both enables high: chk_lock = 1 within 5 cycles of the first non-idle word. After 4 full sequences (192 cycles), chk_err_count = 0 and chk_pattern_idx tracks gen_pattern_idx delayed by 3.
- Corrupt one word (rxd = 0x1234) mid-run: exactly one chk_error pulse, count = 1, lock held, no further errors.
- Force 4 consecutive corrupt words: count = 4, chk_lock falls after the 4th, relocks on the next valid word.
- Hold rxd/rxc at pattern 2 for 12 cycles after lock: dwell-overrun errors on cycles 9 to 12 of the run, count = 4.
- Assert rst for 2 cycles mid-sequence, asynchronously between clk edges: outputs go to reset values immediately, the generator restarts at pattern 0, and the checker re-enters HUNT.
- With XGMII_PATTERN_LB_TIMEOUT_EN, TIMEOUT_CYCLES = 64, rxd = 0x1234 held: chk_timeout rises after 64 cycles and clears when valid loopback is restored and lock is achieved.
